soqpsk_addr_gen: RTL and testbench

SOQPSK_ADDR_GEN -- requirements
Module: soqpsk_addr_gen

---
 rtl/soqpsk_addr_gen.sv | 128 ++++++++++++
 tb/tb_soqpsk_addr_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/soqpsk_addr_gen.sv
// SOQPSK waveform-ROM address generator.
// Buffers one data bit, precodes it into a ternary alpha at each symbol
// boundary, tracks the running quadrant and emits a 9-bit ROM address
// {q, alpha_k, alpha_(k-1), sample} on every enabled sample.
//
// Handshake: a bit is taken on a rising clock edge when bit_valid and
// bit_ready are both high; bit_ready is high exactly when the one-entry
// buffer is empty and reset is low, and bit_valid may be raised or dropped
// at any time without obligation.
module soqpsk_addr_gen #(
    parameter int SPS_LOG2 = 3,
    parameter int ADDR_W   = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              underrun
);

    // Symbol/sample state. Data symbols are held as bits: 1 = +1, 0 = -1.
    logic [SPS_LOG2-1:0] r_s;           // sample index within the symbol
    logic                r_par;         // parity of symbol index k
    logic                r_a1;          // a_(k-1)
    logic                r_a2;          // a_(k-2)
    logic [1:0]          r_alpha_k;     // alpha of the current symbol
    logic [1:0]          r_alpha_km1;   // alpha of the previous symbol
    logic [1:0]          r_q;           // quadrant, running sum of alphas
    logic                r_buf_full;
    logic                r_buf_bit;
    logic [ADDR_W-1:0]   r_address;
    logic                r_addr_valid;
    logic                r_underrun;

    logic                w_boundary;
    logic                w_accept;
    logic                w_ak;
    logic                w_neg;
    logic [1:0]          w_alpha_new;
    logic [1:0]          w_q_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;

    assign bit_ready  = ~r_buf_full & ~reset;
    assign w_accept   = bit_valid & bit_ready;
    assign w_boundary = enable & (r_s == '0);
    // An empty buffer at the boundary yields a_k = -1 (bit 0).
    assign w_ak       = r_buf_full & r_buf_bit;
    // alpha encoding is 2-bit two's complement, so the quadrant update is a plain add.
    assign w_q_nxt    = r_q + r_alpha_k;

    // Precoder: alpha = (-1)^(k+1) * a_(k-1) * (a_k - a_(k-2)) / 2.
    // Nonzero only when a_k differs from a_(k-2); sign is the xor of the three negative factors.
    always_comb begin
        w_alpha_new = 2'b00;
        w_neg       = (~r_par) ^ (~r_a1) ^ (~w_ak);
        if (w_ak != r_a2) begin
            w_alpha_new = w_neg ? 2'b11 : 2'b01;
        end
    end

    // Next address; at a boundary show the freshly updated quadrant and alphas.
    always_comb begin
        w_addr_nxt = ADDR_W'({r_q, r_alpha_k, r_alpha_km1, r_s});
        if (w_boundary) begin
            w_addr_nxt = ADDR_W'({w_q_nxt, w_alpha_new, r_alpha_k, r_s});
        end
    end

    // One-entry input buffer: accept only while empty, a boundary pop empties it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_buf_full <= 1'b0;
            r_buf_bit  <= 1'b0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf_bit  <= bit_in;
        end else if (w_boundary) begin
            r_buf_full <= 1'b0;
        end
    end

    // Sample counter, symbol history, alpha history and quadrant.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s         <= '0;
            r_par       <= 1'b0;
            r_a1        <= 1'b0;
            r_a2        <= 1'b0;
            r_alpha_k   <= 2'b00;
            r_alpha_km1 <= 2'b00;
            r_q         <= 2'b00;
        end else if (enable) begin
            r_s <= r_s + 1'b1;
            if (w_boundary) begin
                r_par       <= ~r_par;
                r_a2        <= r_a1;
                r_a1        <= w_ak;
                r_alpha_km1 <= r_alpha_k;
                r_alpha_k   <= w_alpha_new;
                r_q         <= w_q_nxt;
            end
        end
    end

    // Registered outputs: address holds between enables, valid/underrun are one-cycle pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_address    <= '0;
            r_addr_valid <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_addr_valid <= enable;
            r_underrun   <= w_boundary & ~r_buf_full;
            if (enable) begin
                r_address <= w_addr_nxt;
            end
        end
    end

    assign address    = r_address;
    assign addr_valid = r_addr_valid;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_soqpsk_addr_gen.sv
// Testbench for soqpsk_addr_gen: vector table, hand-written corner
// sequences and a randomized run against a symbol-level reference model.
module tb_soqpsk_addr_gen;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [8:0] address;
    logic       addr_valid;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;

    soqpsk_addr_gen #(.SPS_LOG2(3), .ADDR_W(9)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .address    (address),
        .addr_valid (addr_valid),
        .underrun   (underrun)
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model (symbol level) ----------------
    int         a_q[$];    // symbols +1/-1, a_q[0]=a_(-2), a_q[1]=a_(-1)
    int         al_q[$];   // alpha per symbol
    int         m_n;       // enabled samples since reset
    logic       m_full;
    logic       m_bit;
    logic [8:0] m_addr;
    logic       m_av;
    logic       m_ur;
    logic [1:0] m_q;

    function automatic logic [1:0] enc(input int al);
        if (al > 0) return 2'b01;
        if (al < 0) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_update(input logic rst, input logic en, input logic v, input logic b);
        logic acc;
        int   s, k, ak, sgn, alpha, qsum;
        if (rst) begin
            a_q.delete();
            al_q.delete();
            a_q.push_back(-1);
            a_q.push_back(-1);
            m_n = 0; m_full = 0; m_bit = 0;
            m_addr = '0; m_av = 0; m_ur = 0; m_q = 0;
            return;
        end
        acc  = v && !m_full;
        m_av = en;
        m_ur = 0;
        if (en) begin
            s = m_n % 8;
            if (s == 0) begin
                ak     = (m_full && m_bit) ? 1 : -1;
                m_ur   = !m_full;
                m_full = 0;
                k      = al_q.size();
                a_q.push_back(ak);
                sgn    = (k % 2 == 0) ? -1 : 1;
                alpha  = sgn * a_q[k+1] * (a_q[k+2] - a_q[k]) / 2;
                al_q.push_back(alpha);
            end
            k    = al_q.size() - 1;
            qsum = 0;
            for (int j = 0; j < k; j++) qsum += al_q[j];
            m_q    = 2'(((qsum % 4) + 4) % 4);
            m_addr = {m_q, enc(al_q[k]), (k > 0) ? enc(al_q[k-1]) : 2'b00, 3'(s)};
            m_n++;
        end
        if (acc) begin
            m_full = 1;
            m_bit  = b;
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic step(input logic rst, input logic en, input logic v, input logic b);
        reset = rst; enable = en; bit_valid = v; bit_in = b;
        @(posedge clock);
        model_update(rst, en, v, b);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("mdl_addr", 32'(address), 32'(m_addr));
        check("mdl_av", 32'(addr_valid), 32'(m_av));
        check("mdl_ur", 32'(underrun), 32'(m_ur));
        check("mdl_rdy", 32'(bit_ready), 32'(!m_full && !reset));
        check("mdl_q", 32'(address[8:7]), 32'(m_q));
        n_checks++;
        if (address[6:5] == 2'b10) begin
            n_fail++;
            $display("FAIL alpha_code: got 2 expected 0,1 or 3 at %0t", $time);
        end
    endtask

    typedef struct {
        logic       rst, en, v, b;
        logic [8:0] addr;
        logic       av, ur, rdy;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // Reset, preload bit 1, then two symbols of bit 1 (16 enables).
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            tbl[i+2] = '{1'b0, 1'b1, 1'b1, 1'b1,
                         (i < 8) ? 9'(9'h020 + i) : 9'(9'h0A8 + i - 8),
                         1'b1, 1'b0, (i % 8 == 0)};
        end

        reset = 1'b1; enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        step(1, 0, 0, 0);

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].b);
            check("tbl_addr", 32'(address), 32'(tbl[i].addr));
            check("tbl_av", 32'(addr_valid), 32'(tbl[i].av));
            check("tbl_ur", 32'(underrun), 32'(tbl[i].ur));
            check("tbl_rdy", 32'(bit_ready), 32'(tbl[i].rdy));
        end

        // Continuous zero bits: address cycles 0..7, no underrun.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 64; i++) begin
            step(0, 1, 1, 0);
            check("zero_addr", 32'(address), 32'(i % 8));
            check("zero_ur", 32'(underrun), 0);
        end

        // Underrun at a boundary, with a bit arriving on that same cycle.
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        check("ur_pre_rdy", 32'(bit_ready), 1);
        step(0, 1, 1, 1);
        check("ur_pulse", 32'(underrun), 1);
        check("ur_addr", 32'(address), 32'h088);
        check("ur_rdy", 32'(bit_ready), 0);
        step(0, 1, 0, 0);
        check("ur_clear", 32'(underrun), 0);
        check("ur_addr1", 32'(address), 32'h089);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        check("ur_addr7", 32'(address), 32'h08F);
        step(0, 1, 0, 0);
        check("ur_next_addr", 32'(address), 32'h080);
        check("ur_next_ur", 32'(underrun), 0);

        // Reset at s=4 with the buffer full.
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1);
        check("rst_pre_full", 32'(bit_ready), 0);
        step(1, 1, 1, 1);
        check("rst_addr", 32'(address), 0);
        check("rst_av", 32'(addr_valid), 0);
        check("rst_rdy", 32'(bit_ready), 0);
        check("rst_ur", 32'(underrun), 0);
        step(0, 0, 0, 0);
        check("rst_rel_rdy", 32'(bit_ready), 1);
        step(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 1);
            check("rst_seq_addr", 32'(address), 32'(9'h020 + i));
            check("rst_seq_av", 32'(addr_valid), 1);
        end

        // Randomized run against the reference model.
        step(1, 0, 0, 0);
        check_model();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)));
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
